packet_sender: RTL and testbench

PACKET_SENDER -- requirements
Module: packet_sender

---
 rtl/packet_sender_if.sv | 25 ++
 rtl/packet_sender.sv | 167 ++++++++++++++++
 tb/tb_packet_sender.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/packet_sender_if.sv
// Byte-stream handshake between packet_sender and the network TX FIFO.
`timescale 1ns/1ps
interface packet_sender_if;
  logic [7:0] o_tx_data;
  logic       o_tx_valid;
  logic       i_tx_ready;
  logic       o_tx_sof;
  logic       o_tx_eof;

  modport master (
    output o_tx_data,
    output o_tx_valid,
    output o_tx_sof,
    output o_tx_eof,
    input  i_tx_ready
  );

  modport slave (
    input  o_tx_data,
    input  o_tx_valid,
    input  o_tx_sof,
    input  o_tx_eof,
    output i_tx_ready
  );
endinterface

// File: rtl/packet_sender.sv
// Frames a completed ping-pong RAM packet as sync + header + payload + XOR
// checksum and streams it one byte at a time over a valid/ready interface.
`timescale 1ns/1ps
module packet_sender #(
  parameter logic [7:0]  SYNC0      = 8'hAA,
  parameter logic [7:0]  SYNC1      = 8'h55,
  parameter logic [15:0] MAX_POINTS = 16'd256
) (
  input  logic        i_clk_50m,
  input  logic        i_rst_n,
  input  logic        i_packet_make,
  input  logic        i_packet_pingpang,
  input  logic [15:0] i_packet_points,
  input  logic [15:0] i_scan_counter,
  input  logic [7:0]  i_telegram_no,
  input  logic [15:0] i_first_angle,
  output logic [10:0] o_ram_rdaddr,
  input  logic [7:0]  i_ram_rddata,
  packet_sender_if.master tx,
  output logic        o_busy,
  output logic [7:0]  o_overrun_cnt,
  output logic        o_len_error
);

  typedef enum logic [2:0] {IDLE, HDR, FETCH, PAYLOAD, CKSUM} state_t;

  state_t      state;
  logic        bank;
  logic [15:0] points;
  logic [15:0] scan;
  logic [7:0]  telegram;
  logic [15:0] angle;
  logic [3:0]  hdr_idx;
  logic [9:0]  byte_index;
  logic [9:0]  last_index;
  logic [7:0]  cksum;

  logic       accept;
  logic       len_ok;
  logic [9:0] last_calc;

  assign accept = tx.o_tx_valid && tx.i_tx_ready;
  assign len_ok = (i_packet_points != 16'd0) && (i_packet_points <= MAX_POINTS);
  // Index of the last payload byte, 4*points-1; points of 256 wraps the low byte to 0 on purpose.
  assign last_calc = {i_packet_points[7:0] - 8'd1, 2'b11};

  function automatic logic [7:0] hdr_byte(input logic [3:0] idx);
    case (idx)
      4'd1:    hdr_byte = SYNC1;
      4'd2:    hdr_byte = scan[15:8];
      4'd3:    hdr_byte = scan[7:0];
      4'd4:    hdr_byte = telegram;
      4'd5:    hdr_byte = angle[15:8];
      4'd6:    hdr_byte = angle[7:0];
      4'd7:    hdr_byte = points[15:8];
      4'd8:    hdr_byte = points[7:0];
      default: hdr_byte = SYNC0;
    endcase
  endfunction

  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      bank          <= 1'b0;
      points        <= '0;
      scan          <= '0;
      telegram      <= '0;
      angle         <= '0;
      hdr_idx       <= '0;
      byte_index    <= '0;
      last_index    <= '0;
      cksum         <= '0;
      o_ram_rdaddr  <= '0;
      tx.o_tx_data  <= '0;
      tx.o_tx_valid <= 1'b0;
      tx.o_tx_sof   <= 1'b0;
      tx.o_tx_eof   <= 1'b0;
      o_busy        <= 1'b0;
      o_overrun_cnt <= '0;
      o_len_error   <= 1'b0;
    end else begin
      o_len_error <= 1'b0;

      // A request arriving while busy, including on the final checksum accept, is dropped.
      if (i_packet_make && o_busy && (o_overrun_cnt != 8'hFF)) begin
        o_overrun_cnt <= o_overrun_cnt + 8'd1;
      end

      case (state)
        IDLE: begin
          if (i_packet_make) begin
            if (len_ok) begin
              bank          <= i_packet_pingpang;
              points        <= i_packet_points;
              scan          <= i_scan_counter;
              telegram      <= i_telegram_no;
              angle         <= i_first_angle;
              last_index    <= last_calc;
              hdr_idx       <= '0;
              byte_index    <= '0;
              cksum         <= '0;
              o_ram_rdaddr  <= {i_packet_pingpang, 10'd0};
              tx.o_tx_data  <= SYNC0;
              tx.o_tx_valid <= 1'b1;
              tx.o_tx_sof   <= 1'b1;
              o_busy        <= 1'b1;
              state         <= HDR;
            end else begin
              o_len_error <= 1'b1;
            end
          end
        end

        HDR: begin
          if (accept) begin
            tx.o_tx_sof <= 1'b0;
            if (hdr_idx >= 4'd2) begin
              cksum <= cksum ^ tx.o_tx_data;
            end
            if (hdr_idx == 4'd8) begin
              tx.o_tx_valid <= 1'b0;
              state         <= FETCH;
            end else begin
              hdr_idx      <= hdr_idx + 4'd1;
              tx.o_tx_data <= hdr_byte(hdr_idx + 4'd1);
            end
          end
        end

        // The address has been on the RAM for this whole cycle, so its data is sampled now.
        FETCH: begin
          tx.o_tx_data  <= i_ram_rddata;
          tx.o_tx_valid <= 1'b1;
          state         <= PAYLOAD;
        end

        PAYLOAD: begin
          if (accept) begin
            cksum <= cksum ^ tx.o_tx_data;
            if (byte_index == last_index) begin
              tx.o_tx_data <= cksum ^ tx.o_tx_data;
              tx.o_tx_eof  <= 1'b1;
              state        <= CKSUM;
            end else begin
              byte_index    <= byte_index + 10'd1;
              o_ram_rdaddr  <= {bank, byte_index + 10'd1};
              tx.o_tx_valid <= 1'b0;
              state         <= FETCH;
            end
          end
        end

        CKSUM: begin
          if (accept) begin
            tx.o_tx_valid <= 1'b0;
            tx.o_tx_eof   <= 1'b0;
            o_busy        <= 1'b0;
            state         <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_sender.sv
// Directed and randomized bench for packet_sender against a frame-level reference model.
`timescale 1ns/1ps
module tb_packet_sender;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        make;
  logic        pingpang;
  logic [15:0] points;
  logic [15:0] scan;
  logic [7:0]  tel;
  logic [15:0] angle;
  logic [10:0] rdaddr;
  logic [7:0]  rddata;
  logic        busy;
  logic [7:0]  ovr;
  logic        len_err;

  packet_sender_if tx();

  packet_sender dut (
    .i_clk_50m         (clk),
    .i_rst_n           (rst_n),
    .i_packet_make     (make),
    .i_packet_pingpang (pingpang),
    .i_packet_points   (points),
    .i_scan_counter    (scan),
    .i_telegram_no     (tel),
    .i_first_angle     (angle),
    .o_ram_rdaddr      (rdaddr),
    .i_ram_rddata      (rddata),
    .tx                (tx),
    .o_busy            (busy),
    .o_overrun_cnt     (ovr),
    .o_len_error       (len_err)
  );

  always #10 clk = ~clk;

  // Packet RAM: data for an address is available to be sampled at the next clock edge.
  logic [7:0] mem [0:2047];
  assign rddata = mem[rdaddr];

  int checks = 0;
  int errors = 0;
  int ready_mode = 0;

  logic [7:0]  obs_data [$];
  logic        obs_sof  [$];
  logic        obs_eof  [$];
  logic [10:0] obs_addr [$];
  logic [7:0]  exp_q    [$];
  int          busy_total;
  int          stab_viol;

  initial begin
    tx.i_tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx.i_tx_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom & 1);
    end
  end

  // Stream monitor: records accepted bytes, fetch-cycle addresses and stall stability.
  initial begin
    logic       stall_prev;
    logic [7:0] prev_data;
    logic       prev_sof;
    logic       prev_eof;
    stall_prev = 1'b0;
    prev_data  = '0;
    prev_sof   = 1'b0;
    prev_eof   = 1'b0;
    busy_total = 0;
    stab_viol  = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev && (!tx.o_tx_valid || tx.o_tx_data !== prev_data ||
                           tx.o_tx_sof !== prev_sof || tx.o_tx_eof !== prev_eof))
          stab_viol++;
        if (tx.o_tx_valid && tx.i_tx_ready) begin
          obs_data.push_back(tx.o_tx_data);
          obs_sof.push_back(tx.o_tx_sof);
          obs_eof.push_back(tx.o_tx_eof);
        end
        if (busy && !tx.o_tx_valid) obs_addr.push_back(rdaddr);
        if (busy) busy_total++;
        stall_prev = tx.o_tx_valid && !tx.i_tx_ready;
        prev_data  = tx.o_tx_data;
        prev_sof   = tx.o_tx_sof;
        prev_eof   = tx.o_tx_eof;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference frame built straight from the frame layout rules.
  task automatic model_frame(input int p, input logic b, input logic [15:0] s,
                             input logic [7:0] t, input logic [15:0] a);
    logic [7:0]  chk;
    logic [10:0] ad;
    exp_q = {};
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h55);
    exp_q.push_back(s[15:8]);
    exp_q.push_back(s[7:0]);
    exp_q.push_back(t);
    exp_q.push_back(a[15:8]);
    exp_q.push_back(a[7:0]);
    exp_q.push_back(8'(p >> 8));
    exp_q.push_back(8'(p));
    for (int i = 0; i < 4 * p; i++) begin
      ad = 11'(b) * 11'd1024 + 11'(i);
      exp_q.push_back(mem[ad]);
    end
    chk = 8'h00;
    for (int k = 2; k < exp_q.size(); k++) chk = chk ^ exp_q[k];
    exp_q.push_back(chk);
  endtask

  task automatic apply_stimulus(input int p, input logic b, input logic [15:0] s,
                                input logic [7:0] t, input logic [15:0] a);
    points   = 16'(p);
    pingpang = b;
    scan     = s;
    tel      = t;
    angle    = a;
    make     = 1'b1;
    @(posedge clk);
    #1;
    make     = 1'b0;
    points   = 16'($urandom);
    pingpang = 1'($urandom);
    scan     = 16'($urandom);
    tel      = 8'($urandom);
    angle    = 16'($urandom);
  endtask

  task automatic start_frame(input string tag, input int p, input logic b,
                             input logic [15:0] s, input logic [7:0] t, input logic [15:0] a,
                             output int d0, output int a0, output int bz0);
    d0  = obs_data.size();
    a0  = obs_addr.size();
    bz0 = busy_total;
    model_frame(p, b, s, t, a);
    apply_stimulus(p, b, s, t, a);
    check({tag, " first valid"}, 32'(tx.o_tx_valid), 32'd1);
    check({tag, " first data"}, 32'(tx.o_tx_data), 32'hAA);
    check({tag, " first sof"}, 32'(tx.o_tx_sof), 32'd1);
    check({tag, " busy rise"}, 32'(busy), 32'd1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, " done in budget"}, 32'(busy), 32'd0);
  endtask

  task automatic check_output(input string tag, input int d0, input int a0, input int bz0,
                              input int p, input logic b, input bit timed);
    int n;
    int na;
    int m;
    int sofs;
    int eofs;
    logic [10:0] ea;
    n = obs_data.size() - d0;
    check({tag, " length"}, 32'(n), 32'(exp_q.size()));
    m = (n < exp_q.size()) ? n : exp_q.size();
    for (int i = 0; i < m; i++) begin
      check($sformatf("%s byte%0d", tag, i), 32'(obs_data[d0 + i]), 32'(exp_q[i]));
      if (obs_data[d0 + i] !== exp_q[i]) break;
    end
    sofs = 0;
    eofs = 0;
    for (int i = 0; i < n; i++) begin
      if (obs_sof[d0 + i]) sofs++;
      if (obs_eof[d0 + i]) eofs++;
    end
    check({tag, " sof count"}, 32'(sofs), 32'd1);
    check({tag, " eof count"}, 32'(eofs), 32'd1);
    if (n > 0) begin
      check({tag, " sof on first"}, 32'(obs_sof[d0]), 32'd1);
      check({tag, " eof on last"}, 32'(obs_eof[d0 + n - 1]), 32'd1);
    end
    na = obs_addr.size() - a0;
    check({tag, " fetch count"}, 32'(na), 32'(4 * p));
    m = (na < 4 * p) ? na : 4 * p;
    for (int i = 0; i < m; i++) begin
      ea = 11'(b) * 11'd1024 + 11'(i);
      check($sformatf("%s addr%0d", tag, i), 32'(obs_addr[a0 + i]), 32'(ea));
      if (obs_addr[a0 + i] !== ea) break;
    end
    if (timed) check({tag, " busy cycles"}, 32'(busy_total - bz0), 32'(10 + 8 * p));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " rdaddr"}, 32'(rdaddr), 32'd0);
    check({tag, " tx_data"}, 32'(tx.o_tx_data), 32'd0);
    check({tag, " tx_valid"}, 32'(tx.o_tx_valid), 32'd0);
    check({tag, " tx_sof"}, 32'(tx.o_tx_sof), 32'd0);
    check({tag, " tx_eof"}, 32'(tx.o_tx_eof), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " overrun"}, 32'(ovr), 32'd0);
    check({tag, " len_error"}, 32'(len_err), 32'd0);
  endtask

  initial begin
    int d0, a0, bz0, p, n0, cnt;
    logic b;
    logic [15:0] s, a;
    logic [7:0] t;

    rst_n    = 1'b0;
    make     = 1'b0;
    pingpang = 1'b0;
    points   = '0;
    scan     = '0;
    tel      = '0;
    angle    = '0;
    for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] basic frame");
    for (int i = 0; i < 8; i++) mem[11'h400 + i] = 8'h10 + 8'(i);
    start_frame("basic", 2, 1'b1, 16'h0102, 8'h03, 16'h00A5, d0, a0, bz0);
    wait_idle("basic", 200);
    check_output("basic", d0, a0, bz0, 2, 1'b1, 1'b1);
    if (obs_data.size() >= d0 + 18) check("basic checksum", 32'(obs_data[d0 + 17]), 32'hA7);

    $display("[TB] backpressure");
    ready_mode = 1;
    start_frame("bp", 2, 1'b1, 16'h0102, 8'h03, 16'h00A5, d0, a0, bz0);
    wait_idle("bp", 1000);
    check_output("bp", d0, a0, bz0, 2, 1'b1, 1'b0);
    ready_mode = 0;

    $display("[TB] random frames");
    for (int k = 0; k < 4; k++) begin
      p = $urandom_range(1, 12);
      b = 1'($urandom);
      s = 16'($urandom);
      t = 8'($urandom);
      a = 16'($urandom);
      ready_mode = k & 1;
      start_frame($sformatf("rnd%0d", k), p, b, s, t, a, d0, a0, bz0);
      wait_idle($sformatf("rnd%0d", k), 2000);
      check_output($sformatf("rnd%0d", k), d0, a0, bz0, p, b, (k & 1) == 0);
    end
    ready_mode = 0;

    $display("[TB] length reject");
    foreach (exp_q[i]) exp_q[i] = exp_q[i];
    for (int k = 0; k < 2; k++) begin
      n0 = obs_data.size();
      apply_stimulus((k == 0) ? 0 : 257, 1'b0, 16'h1234, 8'h56, 16'h789A);
      check($sformatf("reject%0d len_error", k), 32'(len_err), 32'd1);
      check($sformatf("reject%0d busy", k), 32'(busy), 32'd0);
      check($sformatf("reject%0d valid", k), 32'(tx.o_tx_valid), 32'd0);
      @(posedge clk);
      #1;
      check($sformatf("reject%0d pulse width", k), 32'(len_err), 32'd0);
      repeat (4) @(posedge clk);
      #1;
      check($sformatf("reject%0d no bytes", k), 32'(obs_data.size() - n0), 32'd0);
      check($sformatf("reject%0d still idle", k), 32'(busy), 32'd0);
    end
    check("reject overrun", 32'(ovr), 32'd0);

    $display("[TB] overrun during frame");
    start_frame("ovr", 3, 1'b0, 16'hBEEF, 8'h42, 16'h0F0F, d0, a0, bz0);
    repeat (3) @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      #1;
      points = 16'd5;
      make   = 1'b1;
      @(posedge clk);
      #1;
      make   = 1'b0;
      repeat (4) @(posedge clk);
    end
    #1;
    cnt = 0;
    while (!tx.o_tx_eof && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("ovr eof reached", 32'(tx.o_tx_eof), 32'd1);
    points = 16'd4;
    make   = 1'b1;
    @(posedge clk);
    #1;
    make   = 1'b0;
    check("ovr busy falls", 32'(busy), 32'd0);
    wait_idle("ovr", 10);
    check_output("ovr", d0, a0, bz0, 3, 1'b0, 1'b1);
    check("ovr count 3", 32'(ovr), 32'd3);
    n0 = obs_data.size();
    repeat (5) @(posedge clk);
    #1;
    check("ovr dropped", 32'(obs_data.size() - n0), 32'd0);

    $display("[TB] capacity and saturation");
    start_frame("cap", 256, 1'b1, 16'($urandom), 8'($urandom), 16'($urandom), d0, a0, bz0);
    for (int k = 0; k < 300; k++) begin
      make = 1'b1;
      @(posedge clk);
      #1;
    end
    make = 1'b0;
    wait_idle("cap", 5000);
    check_output("cap", d0, a0, bz0, 256, 1'b1, 1'b1);
    check("cap last addr", 32'(obs_addr[obs_addr.size() - 1]), 32'h7FF);
    check("cap saturation", 32'(ovr), 32'd255);

    $display("[TB] reset abort");
    start_frame("abort", 8, 1'b0, 16'($urandom), 8'($urandom), 16'($urandom), d0, a0, bz0);
    cnt = 0;
    while ((obs_data.size() - d0) < 14 && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("abort in payload", 32'((obs_data.size() - d0) >= 14), 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    n0 = 0;
    for (int i = d0; i < obs_data.size(); i++) if (obs_eof[i]) n0++;
    check("abort no eof", 32'(n0), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n0 = obs_data.size();
    repeat (4) @(posedge clk);
    #1;
    check("abort waits", 32'(obs_data.size() - n0), 32'd0);
    check("abort idle", 32'(busy), 32'd0);
    ready_mode = 1;
    start_frame("after", 5, 1'b1, 16'($urandom), 8'($urandom), 16'($urandom), d0, a0, bz0);
    wait_idle("after", 2000);
    check_output("after", d0, a0, bz0, 5, 1'b1, 1'b0);
    ready_mode = 0;

    check("stall stability", 32'(stab_viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
